// File: rtl/m68k_intc_if.sv
// m68k_intc_if: register bus and 68000 interrupt-acknowledge signals of m68k_intc.
// slave = the interrupt controller, master = CPU bus glue driving registers and IACK cycles.
interface m68k_intc_if;
    logic        reg_cs;
    logic        reg_we;
    logic [2:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic [15:0] reg_rdata;
    logic        intr_cycle_n;
    logic [2:0]  iack_level;
    logic [2:0]  ipl_n;
    logic [7:0]  intr_vector;
    logic        dtack_n;
    logic        vpa_n;
    logic        berr_n;

    modport slave (
        input  reg_cs, reg_we, reg_addr, reg_wdata, intr_cycle_n, iack_level,
        output reg_rdata, ipl_n, intr_vector, dtack_n, vpa_n, berr_n
    );

    modport master (
        output reg_cs, reg_we, reg_addr, reg_wdata, intr_cycle_n, iack_level,
        input  reg_rdata, ipl_n, intr_vector, dtack_n, vpa_n, berr_n
    );
endinterface

// File: rtl/m68k_intc.sv
// m68k_intc: parametrised 68000 interrupt controller (ipl encoding, IACK with DTACK/VPA/BERR).
// Optional INTC_RR_PRIO_EN: per-level rotating priority pointer instead of lowest-index-wins.
module m68k_intc #(
    parameter int         NUM_SRC  = 16,
    parameter logic [7:0] VEC_BASE = 8'h40
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_n,
    m68k_intc_if.slave         bus
);
    typedef enum logic [2:0] {
        IDLE, RESOLVE, ACK_VEC, ACK_AVEC, ACK_SPUR, WAIT_END
    } state_t;

    state_t state_reg, state_next;

    logic [NUM_SRC-1:0] src_meta_reg, src_sync_reg, raw_prev_reg, raw;
    logic [NUM_SRC-1:0] ien_reg, edge_reg, pend_reg, avec_reg;
    logic [NUM_SRC-1:0] pend_next, pend_set, pend_clr, act, act_snap_reg;
    logic [2:0]         level_reg [NUM_SRC];
    logic [2:0]         level16 [16];

    logic [2:0]  ipl_n_reg, max_level;
    logic [7:0]  vector_reg;
    logic        dtack_n_reg, vpa_n_reg, berr_n_reg;
    logic [15:0] rdata_reg, rd_word;
    logic        wr, rd, cyc_n;
    logic        found, sel_avec, resolve_hit;
    logic [3:0]  sel_idx;

`ifdef INTC_RR_PRIO_EN
    logic [3:0] rr_ptr_reg [8];
    int         cand;
`endif

    assign wr    = bus.reg_cs & bus.reg_we;
    assign rd    = bus.reg_cs & ~bus.reg_we;
    assign cyc_n = bus.intr_cycle_n;
    assign raw   = ~src_sync_reg;

    // Synchroniser idles high (inactive) so leaving reset never looks like a request edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_meta_reg <= '1;
            src_sync_reg <= '1;
            raw_prev_reg <= '0;
        end else begin
            src_meta_reg <= src_n;
            src_sync_reg <= src_meta_reg;
            raw_prev_reg <= raw;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign pend_set[gi]  = raw[gi] & ~raw_prev_reg[gi];
            assign pend_clr[gi]  = (wr && bus.reg_addr == 3'd2 && bus.reg_wdata[gi]) ||
                                   (resolve_hit && sel_idx == 4'(gi));
            assign pend_next[gi] = edge_reg[gi] ? (pend_set[gi] | (pend_reg[gi] & ~pend_clr[gi]))
                                                : raw[gi];
            assign act[gi]       = pend_reg[gi] & ien_reg[gi] & (level_reg[gi] != 3'd0);
        end
        for (gi = 0; gi < 16; gi++) begin : g_lvl16
            if (gi < NUM_SRC) begin : g_real
                assign level16[gi] = level_reg[gi];
            end else begin : g_zero
                assign level16[gi] = 3'd0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            ien_reg  <= '0;
            edge_reg <= '0;
            avec_reg <= '0;
            pend_reg <= '0;
            for (int i = 0; i < NUM_SRC; i++) level_reg[i] <= '0;
        end else begin
            pend_reg <= pend_next;
            if (wr && bus.reg_addr == 3'd0) ien_reg  <= bus.reg_wdata[NUM_SRC-1:0];
            if (wr && bus.reg_addr == 3'd1) edge_reg <= bus.reg_wdata[NUM_SRC-1:0];
            if (wr && bus.reg_addr == 3'd3) avec_reg <= bus.reg_wdata[NUM_SRC-1:0];
            for (int i = 0; i < NUM_SRC; i++)
                if (wr && bus.reg_addr[2] && bus.reg_addr[1:0] == 2'(i / 4))
                    level_reg[i] <= bus.reg_wdata[(i % 4) * 4 +: 3];
        end
    end

    always_comb begin
        rd_word = '0;
        case (bus.reg_addr)
            3'd0:    rd_word[NUM_SRC-1:0] = ien_reg;
            3'd1:    rd_word[NUM_SRC-1:0] = edge_reg;
            3'd2:    rd_word[NUM_SRC-1:0] = pend_reg;
            3'd3:    rd_word[NUM_SRC-1:0] = avec_reg;
            default: for (int k = 0; k < 4; k++)
                         rd_word[k * 4 +: 3] = level16[{bus.reg_addr[1:0], 2'(k)}];
        endcase
    end

    always_comb begin
        max_level = '0;
        for (int i = 0; i < NUM_SRC; i++)
            if (act[i] && level_reg[i] > max_level) max_level = level_reg[i];
    end

    // Selection runs on the request snapshot taken when the IACK started; the loops scan
    // from the far end so the last hit written is the highest-priority candidate.
    always_comb begin
        found    = 1'b0;
        sel_idx  = '0;
        sel_avec = 1'b0;
`ifdef INTC_RR_PRIO_EN
        cand = 0;
        for (int off = NUM_SRC - 1; off >= 0; off--) begin
            cand = (int'(rr_ptr_reg[bus.iack_level]) + off) % NUM_SRC;
            if (act_snap_reg[cand] && level_reg[cand] == bus.iack_level) begin
                found    = 1'b1;
                sel_idx  = 4'(cand);
                sel_avec = avec_reg[cand];
            end
        end
`else
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (act_snap_reg[i] && level_reg[i] == bus.iack_level) begin
                found    = 1'b1;
                sel_idx  = 4'(i);
                sel_avec = avec_reg[i];
            end
        end
`endif
    end

    assign resolve_hit = (state_reg == RESOLVE) && !cyc_n && found;

`ifdef INTC_RR_PRIO_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int l = 0; l < 8; l++) rr_ptr_reg[l] <= '0;
        end else if (resolve_hit) begin
            rr_ptr_reg[bus.iack_level] <= (sel_idx == 4'(NUM_SRC - 1)) ? 4'd0 : sel_idx + 4'd1;
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (!cyc_n) state_next = RESOLVE;
            RESOLVE: begin
                if (cyc_n)         state_next = WAIT_END;
                else if (!found)   state_next = ACK_SPUR;
                else if (sel_avec) state_next = ACK_AVEC;
                else               state_next = ACK_VEC;
            end
            ACK_VEC, ACK_AVEC, ACK_SPUR: if (cyc_n) state_next = WAIT_END;
            WAIT_END: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they come straight off flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            dtack_n_reg  <= 1'b1;
            vpa_n_reg    <= 1'b1;
            berr_n_reg   <= 1'b1;
            vector_reg   <= '0;
            ipl_n_reg    <= 3'b111;
            rdata_reg    <= '0;
            act_snap_reg <= '0;
        end else begin
            state_reg   <= state_next;
            dtack_n_reg <= (state_next != ACK_VEC);
            vpa_n_reg   <= (state_next != ACK_AVEC);
            berr_n_reg  <= (state_next != ACK_SPUR);
            ipl_n_reg   <= ~max_level;
            if (rd) rdata_reg <= rd_word;
            if (state_reg == IDLE && !cyc_n) act_snap_reg <= act;
            if (state_reg == RESOLVE && !cyc_n)
                vector_reg <= (found && !sel_avec) ? VEC_BASE + 8'(sel_idx) : 8'h00;
        end
    end

    assign bus.reg_rdata   = rdata_reg;
    assign bus.ipl_n       = ipl_n_reg;
    assign bus.intr_vector = vector_reg;
    assign bus.dtack_n     = dtack_n_reg;
    assign bus.vpa_n       = vpa_n_reg;
    assign bus.berr_n      = berr_n_reg;
endmodule
